// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared VGA 640x480@60 timing constants and the coordinate type used by
//   vga_timing_gen, color_mapper and the ball/sprite logic.
//   - DEF_* : default visible/porch/sync sizes (pixels or lines)
//   - DEF_H_TOTAL / DEF_V_TOTAL : full line / frame lengths
//   - DEF_HS_* / DEF_VS_* : first and last counter value of each sync pulse
//   - coord_t : 10-bit unsigned raster coordinate
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Inclusive sync windows: HS 656..751, VS 490..491 for the defaults.
    localparam int DEF_HS_FIRST = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HS_LAST  = DEF_HS_FIRST + DEF_H_SYNC - 1;
    localparam int DEF_VS_FIRST = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VS_LAST  = DEF_VS_FIRST + DEF_V_SYNC - 1;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay
//   pix_ce-gated shift register that re-times the HS/VS/BLANK_N bits so they
//   line up with a pipelined pixel-colour path.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     ce         : advance enable (one Clk per pixel)
//     din        : {hs, vs, blank_n} from the decode register
//     dout       : din delayed by DEPTH pixel times
//   Every stage resets to RST_VAL so the outputs read as idle (sync high,
//   blanked) until real decode values have propagated through.
module vga_sync_delay #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= {DEPTH{RST_VAL}};
        end else if (ce) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60 raster timing from the 50 MHz system clock.
//   Ports:
//     Clk, Reset          : 50 MHz clock, synchronous active-high reset
//     VGA_Clk, pix_ce     : pixel clock (Clk/2) and its one-Clk enable
//     DrawX, DrawY        : raster counters 0..H_TOTAL-1 / 0..V_TOTAL-1
//     VGA_HS, VGA_VS      : active-low syncs, registered decode of the counters
//     VGA_BLANK_N         : high inside the visible region
//     VGA_SYNC_N          : tied low
//     line_start          : one-Clk pulse with the DrawX wrap
//     frame_start         : one-Clk pulse with the DrawX+DrawY wrap
//   Build option: define VGA_TIMING_SYNC_DELAY_EN to delay HS/VS/BLANK_N by a
//   further two pixel times (vga_sync_delay), matching a registered
//   sprite-ROM + palette colour path. Counters and strobes are unaffected.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic   Clk,
    input  logic   Reset,
    output logic   VGA_Clk,
    output logic   pix_ce,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   VGA_HS,
    output logic   VGA_VS,
    output logic   VGA_BLANK_N,
    output logic   VGA_SYNC_N,
    output logic   line_start,
    output logic   frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t X_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t X_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t Y_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic   pix_q;
    coord_t x_q, y_q;
    logic   ls_q, fs_q;

    // Counters commit on the same edge that raises pix_ce, so the cycle in
    // which pix_ce = 1 already shows the new coordinate (and any wrap strobe).
    // The first edge after reset therefore moves DrawX 0 -> 1 with no strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            pix_q <= ~pix_q;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            if (!pix_q) begin
                if (x_q == X_LAST) begin
                    x_q  <= '0;
                    ls_q <= 1'b1;
                    if (y_q == Y_LAST) begin
                        y_q  <= '0;
                        fs_q <= 1'b1;
                    end else begin
                        y_q <= y_q + coord_t'(1);
                    end
                end else begin
                    x_q <= x_q + coord_t'(1);
                end
            end
        end
    end

    logic hs_d, vs_d, bn_d;
    logic hs_q, vs_q, bn_q;

    always_comb begin
        hs_d = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
        vs_d = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
        bn_d = (x_q < X_VIS) && (y_q < Y_VIS);
    end

    // Decode register runs every Clk, giving one Clk of latency behind the
    // counters; within a pixel it settles before the next pix_ce.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            bn_q <= 1'b0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            bn_q <= bn_d;
        end
    end

`ifdef VGA_TIMING_SYNC_DELAY_EN
    logic [2:0] sync_dly;

    vga_sync_delay #(
        .DEPTH   (2),
        .WIDTH   (3),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .clk   (Clk),
        .reset (Reset),
        .ce    (pix_q),
        .din   ({hs_q, vs_q, bn_q}),
        .dout  (sync_dly)
    );

    assign {VGA_HS, VGA_VS, VGA_BLANK_N} = sync_dly;
`else
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = bn_q;
`endif

    // VGA_Clk is the toggle flop itself: its rising edge is the pix_ce cycle.
    assign VGA_Clk     = pix_q;
    assign pix_ce      = pix_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign VGA_SYNC_N  = 1'b0;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule
